// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - uncached data-access sequencer for the memory stage
// Issues one load/store at a time on the SRAM-like bus and stalls the pipeline until it retires.
module dmem_access_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              req_valid,
  input  logic              req_wr,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wstrb,
  input  logic              exp_flush,
  output logic              stall_out,
  output logic [31:0]       rdata_out,
  output logic              rdata_valid,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [31:0]       data_wdata,
  output logic [3:0]        data_wstrb,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DONE
  } state_t;

  state_t state;
  logic   killed;
  logic   kill_now;

  // A flush that lands in the same cycle as data_ok must still discard the result.
  assign kill_now = killed | exp_flush;

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state      <= IDLE;
      killed     <= 1'b0;
      data_req   <= 1'b0;
      data_wr    <= 1'b0;
      data_size  <= 2'd0;
      data_addr  <= '0;
      data_wdata <= 32'd0;
      data_wstrb <= 4'd0;
      rdata_out  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && !exp_flush) begin
            data_wr    <= req_wr;
            data_size  <= req_size;
            data_addr  <= req_addr;
            data_wdata <= req_wdata;
            data_wstrb <= req_wstrb;
            data_req   <= 1'b1;
            state      <= ADDR;
          end
        end
        ADDR: begin
          // The address phase is never withdrawn; a flush only marks it for draining.
          if (exp_flush) killed <= 1'b1;
          if (data_addr_ok) begin
            data_req <= 1'b0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (data_data_ok) begin
            if (kill_now) begin
              killed <= 1'b0;
              state  <= IDLE;
            end else begin
              if (!data_wr) rdata_out <= data_rdata;
              state <= DONE;
            end
          end else if (exp_flush) begin
            killed <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign stall_out   = req_valid && !exp_flush && (state != DONE);
  assign rdata_valid = (state == DONE) && !data_wr && !exp_flush;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - randomized self-checking bench for dmem_access_ctrl
// Expected behaviour comes from a per-transaction timeline (3 + addr wait + data wait cycles).
module tb_dmem_access_ctrl;
  localparam int ADDR_W = 32;

  logic              Clk = 1'b0;
  logic              Clr;
  logic              req_valid, req_wr, exp_flush;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_wstrb;
  logic              stall_out, rdata_valid, data_req, data_wr;
  logic [31:0]       rdata_out, data_wdata, data_rdata;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [3:0]        data_wstrb;
  logic              data_addr_ok, data_data_ok;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_rdata = 32'd0;

  always #5 Clk = ~Clk;

  dmem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
    .Clk(Clk), .Clr(Clr),
    .req_valid(req_valid), .req_wr(req_wr), .req_size(req_size), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .exp_flush(exp_flush),
    .stall_out(stall_out), .rdata_out(rdata_out), .rdata_valid(rdata_valid),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive_idle();
    req_valid = 0; req_wr = 0; req_size = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
    exp_flush = 0; data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
  endtask

  task automatic drive_req(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb);
    req_valid = 1; req_wr = wr; req_size = size; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
  endtask

  // One transaction starting in IDLE: cycle 0 latch, 1..1+aw ADDR, then DATA, DONE at 3+aw+dw.
  task automatic run_txn(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb, input logic [31:0] rd,
                         input int aw, input int dw, input logic fl_done);
    int n;
    logic exp_stall, exp_req, exp_rv;
    n = 3 + aw + dw;
    for (int c = 0; c <= n; c++) begin
      drive_req(wr, size, addr, wdata, wstrb);
      exp_flush = fl_done && (c == n);
      if (c == 1 + aw) data_addr_ok = 1;
      else if (c == 0 || c >= 2 + aw) data_addr_ok = 1'($urandom_range(1));
      else data_addr_ok = 0;
      if (c == 2 + aw + dw) data_data_ok = 1;
      else if (c < 2 + aw || c == n) data_data_ok = 1'($urandom_range(1));
      else data_data_ok = 0;
      data_rdata = (c == 2 + aw + dw) ? rd : $urandom;
      #3;
      exp_stall = (c < n);
      exp_req   = (c >= 1) && (c <= 1 + aw);
      exp_rv    = (c == n) && !wr && !fl_done;
      if (c == n && !wr) exp_rdata = rd;
      vectors++;
      if (stall_out !== exp_stall) begin
        miscompares++; $display("FAIL txn_stall c=%0d got=%b exp=%b", c, stall_out, exp_stall);
      end
      vectors++;
      if (data_req !== exp_req) begin
        miscompares++; $display("FAIL txn_data_req c=%0d got=%b exp=%b", c, data_req, exp_req);
      end
      vectors++;
      if (rdata_valid !== exp_rv) begin
        miscompares++; $display("FAIL txn_rdata_valid c=%0d got=%b exp=%b", c, rdata_valid, exp_rv);
      end
      vectors++;
      if (rdata_out !== exp_rdata) begin
        miscompares++; $display("FAIL txn_rdata_out c=%0d got=%h exp=%h", c, rdata_out, exp_rdata);
      end
      if (c >= 1) begin
        vectors++;
        if ({data_wr, data_size, data_addr, data_wdata, data_wstrb} !== {wr, size, addr, wdata, wstrb}) begin
          miscompares++;
          $display("FAIL txn_bus_fields c=%0d got=%b/%0d/%h/%h/%b exp=%b/%0d/%h/%h/%b", c,
                   data_wr, data_size, data_addr, data_wdata, data_wstrb, wr, size, addr, wdata, wstrb);
        end
      end
      next_cycle();
    end
    drive_idle();
  endtask

  task automatic test_reset();
    drive_idle();
    Clr = 1;
    next_cycle(); next_cycle();
    vectors++;
    if ({data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb} !== 72'd0) begin
      miscompares++; $display("FAIL reset_bus got=%b/%h/%h exp=0", data_req, data_addr, data_wdata);
    end
    vectors++;
    if ({rdata_valid, rdata_out, stall_out} !== 34'd0) begin
      miscompares++; $display("FAIL reset_rdata got=%b/%h/%b exp=0/0/0", rdata_valid, rdata_out, stall_out);
    end
    req_valid = 1;
    #1;
    vectors++;
    if (stall_out !== 1'b1) begin
      miscompares++; $display("FAIL reset_stall_follows_req got=%b exp=1", stall_out);
    end
    req_valid = 0;
    next_cycle();
    Clr = 0;
    next_cycle();
  endtask

  task automatic test_word_load();
    run_txn(0, 2, 32'h1FC0_0010, 32'h0, 4'hF, 32'hDEADBEEF, 0, 0, 0);
  endtask

  task automatic test_store_delayed();
    run_txn(1, 0, 32'h1FC0_0022, 32'h00AB_0000, 4'b0100, 32'h5A5A5A5A, 2, 3, 0);
  endtask

  task automatic test_back_to_back();
    run_txn(0, 2, 32'h0000_1000, 32'h0, 4'hF, 32'h11111111, 0, 0, 0);
    run_txn(0, 2, 32'h0000_1004, 32'h0, 4'hF, 32'h22222222, 0, 0, 0);
  endtask

  task automatic test_idle_flush();
    drive_idle();
    req_valid = 1; exp_flush = 1;
    #3;
    vectors++;
    if (stall_out !== 1'b0) begin
      miscompares++; $display("FAIL idle_flush_stall got=%b exp=0", stall_out);
    end
    next_cycle();
    drive_idle();
    #3;
    vectors++;
    if (data_req !== 1'b0) begin
      miscompares++; $display("FAIL idle_flush_no_issue got=%b exp=0", data_req);
    end
    next_cycle();
  endtask

  task automatic test_flush_data();
    drive_idle();
    drive_req(0, 2, 32'h0000_2000, 32'h0, 4'hF);
    next_cycle();                                   // IDLE latch
    data_addr_ok = 1;
    next_cycle();                                   // ADDR accepted
    data_addr_ok = 0; exp_flush = 1;
    #3;
    vectors++;
    if ({stall_out, data_req, rdata_valid} !== 3'b000) begin
      miscompares++; $display("FAIL flush_data_cycle got=%b%b%b exp=000", stall_out, data_req, rdata_valid);
    end
    next_cycle();
    exp_flush = 0;
    drive_req(0, 2, 32'h0000_3000, 32'h0, 4'hF);
    #3;
    vectors++;
    if (stall_out !== 1'b1) begin
      miscompares++; $display("FAIL flush_data_blocked got=%b exp=1", stall_out);
    end
    next_cycle();
    data_data_ok = 1; data_rdata = 32'h12345678;
    #3;
    vectors++;
    if ({stall_out, rdata_valid} !== 2'b10) begin
      miscompares++; $display("FAIL flush_data_drain got=%b%b exp=10", stall_out, rdata_valid);
    end
    vectors++;
    if (data_addr !== 32'h0000_2000) begin
      miscompares++; $display("FAIL flush_data_addr_held got=%h exp=%h", data_addr, 32'h0000_2000);
    end
    next_cycle();
    data_data_ok = 0;
    run_txn(0, 2, 32'h0000_3000, 32'h0, 4'hF, 32'h0BADF00D, 1, 0, 0);
  endtask

  task automatic test_flush_addr();
    drive_idle();
    drive_req(0, 1, 32'h0000_4002, 32'h0, 4'hF);
    next_cycle();
    exp_flush = 1;
    #3;
    vectors++;
    if ({stall_out, data_req} !== 2'b01) begin
      miscompares++; $display("FAIL flush_addr_cycle got=%b%b exp=01", stall_out, data_req);
    end
    next_cycle();
    exp_flush = 0;
    #3;
    vectors++;
    if ({stall_out, data_req} !== 2'b11) begin
      miscompares++; $display("FAIL flush_addr_hold got=%b%b exp=11", stall_out, data_req);
    end
    next_cycle();
    data_addr_ok = 1;
    #3;
    vectors++;
    if (data_req !== 1'b1) begin
      miscompares++; $display("FAIL flush_addr_req_until_ok got=%b exp=1", data_req);
    end
    next_cycle();
    data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'hCAFEF00D;
    #3;
    vectors++;
    if ({stall_out, data_req, rdata_valid} !== 3'b100) begin
      miscompares++; $display("FAIL flush_addr_drain got=%b%b%b exp=100", stall_out, data_req, rdata_valid);
    end
    next_cycle();
    drive_idle();
    #3;
    vectors++;
    if ({rdata_valid, stall_out, data_req, rdata_out} !== {3'b000, exp_rdata}) begin
      miscompares++; $display("FAIL flush_addr_discard got=%b%b%b/%h exp=000/%h",
                              rdata_valid, stall_out, data_req, rdata_out, exp_rdata);
    end
    next_cycle();
  endtask

  task automatic test_clr_mid();
    drive_idle();
    drive_req(0, 2, 32'h0000_5000, 32'h0, 4'hF);
    next_cycle();
    data_addr_ok = 1;
    next_cycle();
    data_addr_ok = 0;
    #3;
    Clr = 1;
    exp_rdata = 32'd0;
    #1;
    vectors++;
    if ({data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb, rdata_valid, rdata_out} !== 105'd0) begin
      miscompares++; $display("FAIL clr_mid_outputs got=%b/%h/%b/%h exp=0", data_req, data_addr, rdata_valid, rdata_out);
    end
    vectors++;
    if (stall_out !== 1'b1) begin
      miscompares++; $display("FAIL clr_mid_stall got=%b exp=1", stall_out);
    end
    next_cycle();
    Clr = 0;
    drive_idle();
    next_cycle();
    run_txn(0, 2, 32'h0000_6000, 32'h0, 4'hF, 32'h600DCAFE, 0, 1, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic wr;
      logic [1:0] size;
      wr   = 1'($urandom_range(1));
      size = 2'($urandom_range(2));
      run_txn(wr, size, $urandom, $urandom, 4'($urandom), $urandom,
              int'($urandom_range(3)), int'($urandom_range(3)), ($urandom_range(7) == 0));
    end
  endtask

  initial begin
    Clr = 1;
    drive_idle();
    test_reset();
    test_word_load();
    test_store_delayed();
    test_back_to_back();
    test_idle_flush();
    test_flush_data();
    test_flush_addr();
    test_clr_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
